// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store engine between the control unit and memory. Takes one request,
//   checks alignment, runs the memory enable / MFC handshake, and performs lane
//   steering for stores and lane extraction plus sign/zero extension for loads.
//
//   Optional feature: define MAU_TIMEOUT_EN to abort a WAIT that sees no MFC
//   for TIMEOUT consecutive cycles (bus fault). Without it WAIT holds until MFC
//   or reset.
//
// Ports
//   i_clk        clock, rising edge
//   i_clr        asynchronous active-high reset
//   i_start      request strobe, sampled only in IDLE
//   i_rw         1 = load, 0 = store
//   i_size       00 byte, 01 halfword, 10 word, 11 reserved
//   i_sign_ext   loads: 1 = sign-extend, 0 = zero-extend
//   i_addr       byte address
//   i_wdata      store data (low bytes used per size)
//   o_busy       high in every state except IDLE
//   o_done       one-cycle pulse, access complete
//   o_fault      one-cycle pulse, access aborted
//   o_rdata      load result, held until the next completed load
//   o_mem_en     memory enable
//   o_mem_rw     latched read/write
//   o_mem_addr   latched address with bits [1:0] cleared
//   o_mem_wdata  lane-replicated store data
//   o_mem_size   latched size
//   i_mem_rdata  full aligned word from memory
//   i_mfc        memory function complete
//
// state | meaning
// IDLE  | waiting for i_start
// CHECK | alignment/size check; enable raised here when legal
// WAIT  | enable held until MFC (or timeout when enabled)
// DONE  | completion pulse; load result was written on entry
// FLT   | fault pulse; no memory access took place (or it timed out)

module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_start,
    input  logic              i_rw,
    input  logic [1:0]        i_size,
    input  logic              i_sign_ext,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fault,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_en,
    output logic              o_mem_rw,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [1:0]        o_mem_size,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mfc
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_FLT   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_rw;
    logic [1:0]        r_size;
    logic              r_sign_ext;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic [DATA_W-1:0] w_wdata_rep;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic              w_misalign;
    logic              w_wait_tc;

    // Store data is replicated across all lanes so memory only has to mask.
    always_comb begin
        w_wdata_rep = i_wdata;
        case (i_size)
            2'b00:   w_wdata_rep = {(DATA_W/8){i_wdata[7:0]}};
            2'b01:   w_wdata_rep = {(DATA_W/16){i_wdata[15:0]}};
            default: w_wdata_rep = i_wdata;
        endcase
    end

    assign w_byte = i_mem_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = i_mem_rdata[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load = i_mem_rdata;
        case (r_size)
            2'b00:   w_load = {{(DATA_W-8){r_sign_ext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{(DATA_W-16){r_sign_ext & w_half[15]}}, w_half};
            default: w_load = i_mem_rdata;
        endcase
    end

    assign w_misalign = (r_size == 2'b11)
                      | ((r_size == 2'b01) & r_lane[0])
                      | ((r_size == 2'b10) & (|r_lane));

`ifdef MAU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] r_wait_cnt;

    // Down-counter loaded on WAIT entry; terminal count marks the last
    // allowed MFC-low cycle. MFC on that cycle still completes normally.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_CHECK) begin
            r_wait_cnt <= CNT_W'(TIMEOUT - 1);
        end else if ((r_state == S_WAIT) && !i_mfc && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    assign w_wait_tc = (r_wait_cnt == '0);
`else
    assign w_wait_tc = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        o_mem_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_misalign) begin
                    w_next = S_FLT;
                end else begin
                    o_mem_en = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                o_mem_en = 1'b1;
                if (i_mfc) begin
                    o_mem_en = 1'b0;
                    w_next   = S_DONE;
                end else if (w_wait_tc) begin
                    o_mem_en = 1'b0;
                    w_next   = S_FLT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_FLT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_rw        <= 1'b0;
            r_size      <= 2'b00;
            r_sign_ext  <= 1'b0;
            r_lane      <= 2'b00;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_rw        <= i_rw;
                r_size      <= i_size;
                r_sign_ext  <= i_sign_ext;
                r_lane      <= i_addr[1:0];
                r_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                r_mem_wdata <= w_wdata_rep;
            end
            if ((r_state == S_WAIT) && i_mfc && r_rw) begin
                r_rdata <= w_load;
            end
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_fault     = (r_state == S_FLT);
    assign o_rdata     = r_rdata;
    assign o_mem_rw    = r_rw;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_size  = r_size;

endmodule
